fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the instruction memory and downstream-feeding the decoder.
- Owns the program counter and drives the memory address; captures the returned 8-bit instruction.
- Presents instructions to decode through a 2-entry buffer with a valid/ready handshake.
- Handles PC redirects (branch/jump resolved in execute) and halt detection.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, decode handshake, redirect and status.
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] leEndereco;
    logic [DATA_W-1:0] instrucao;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              halted;
    logic [15:0]       fetch_count;

    modport master (
        output leEndereco, inst_out, inst_pc, inst_valid, halted, fetch_count,
        input  instrucao, inst_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  leEndereco, inst_out, inst_pc, inst_valid, halted, fetch_count,
        output instrucao, inst_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, tracks the one-cycle memory read, and feeds decode
// through a 2-entry FIFO with redirect flush and halt detection.
module fetch_unit #(
    parameter int               ADDR_W     = 8,
    parameter int               DATA_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = 8'h00,
    parameter logic [DATA_W-1:0] HALT_INSTR = 8'b00110000
) (
    input logic                 clock,
    input logic                 reset,
    fetch_unit_if.master        bus
);
    logic [ADDR_W-1:0] r_pc;
    logic              r_inFlight;
    logic [ADDR_W-1:0] r_inFlightPc;
    logic [DATA_W-1:0] r_bufData [0:1];
    logic [ADDR_W-1:0] r_bufPc   [0:1];
    logic              r_rdPtr;
    logic              r_wrPtr;
    logic [1:0]        r_count;
    logic              r_haltSeen;
    logic              r_halted;
    logic [15:0]       r_fetchCount;

    logic              w_valid;
    logic              w_redir;
    logic              w_deqRaw;
    logic              w_deq;
    logic              w_capture;
    logic              w_capHalt;
    logic [2:0]        w_occNext;
    logic              w_issue;
    logic              w_haltAccept;

    // Redirects are dead once halted; a redirect also suppresses the dequeue in its cycle.
    always_comb begin
        w_valid      = (r_count != 2'd0);
        w_redir      = bus.redirect_valid & ~r_halted;
        w_deqRaw     = w_valid & bus.inst_ready;
        w_deq        = w_deqRaw & ~w_redir;
        w_capture    = r_inFlight & ~w_redir;
        w_capHalt    = r_inFlight & (bus.instrucao == HALT_INSTR);
        w_occNext    = {1'b0, r_count} + {2'b00, r_inFlight} - {2'b00, w_deqRaw};
        w_issue      = ~r_haltSeen & ~r_halted & ~bus.redirect_valid & ~w_capHalt
                       & (w_occNext <= 3'd1);
        w_haltAccept = w_deq & (r_bufData[r_rdPtr] == HALT_INSTR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_inFlight   <= 1'b0;
            r_inFlightPc <= '0;
            r_bufData[0] <= '0;
            r_bufData[1] <= '0;
            r_bufPc[0]   <= '0;
            r_bufPc[1]   <= '0;
            r_rdPtr      <= 1'b0;
            r_wrPtr      <= 1'b0;
            r_count      <= 2'd0;
            r_haltSeen   <= 1'b0;
            r_halted     <= 1'b0;
            r_fetchCount <= 16'd0;
        end else if (w_redir) begin
            r_pc       <= bus.redirect_target;
            r_inFlight <= 1'b0;
            r_rdPtr    <= 1'b0;
            r_wrPtr    <= 1'b0;
            r_count    <= 2'd0;
            r_haltSeen <= 1'b0;
        end else begin
            r_inFlight <= w_issue;
            if (w_issue) begin
                r_pc         <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                r_inFlightPc <= r_pc;
            end
            if (w_deq && r_fetchCount != 16'hFFFF)
                r_fetchCount <= r_fetchCount + 16'd1;
            if (w_capture && w_capHalt)
                r_haltSeen <= 1'b1;
            // The halt word is always the last entry, so accepting it empties the buffer.
            if (w_haltAccept) begin
                r_halted <= 1'b1;
                r_rdPtr  <= 1'b0;
                r_wrPtr  <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_capture) begin
                    r_bufData[r_wrPtr] <= bus.instrucao;
                    r_bufPc[r_wrPtr]   <= r_inFlightPc;
                    r_wrPtr            <= ~r_wrPtr;
                end
                if (w_deq)
                    r_rdPtr <= ~r_rdPtr;
                case ({w_capture, w_deq})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.leEndereco  = r_pc;
    assign bus.inst_out    = r_bufData[r_rdPtr];
    assign bus.inst_pc     = r_bufPc[r_rdPtr];
    assign bus.inst_valid  = w_valid;
    assign bus.halted      = r_halted;
    assign bus.fetch_count = r_fetchCount;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, halt, wrap and async reset.
module tb_fetch_unit;
    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] mem [0:255];

    fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    fetch_unit u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Instruction memory with one cycle of read latency.
    always @(posedge clock) bus.instrucao <= mem[bus.leEndereco];

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [7:0] target);
        bus.inst_ready      = ready;
        bus.redirect_valid  = redir;
        bus.redirect_target = target;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [7:0] eAddr, input logic eValid,
                              input logic [7:0] eOut, input logic [7:0] ePc,
                              input logic [15:0] eFc, input logic eHalt);
        checkOutput({tag, ".addr"},   16'(bus.leEndereco), 16'(eAddr));
        checkOutput({tag, ".valid"},  16'(bus.inst_valid), 16'(eValid));
        if (eValid) begin
            checkOutput({tag, ".out"}, 16'(bus.inst_out), 16'(eOut));
            checkOutput({tag, ".pc"},  16'(bus.inst_pc),  16'(ePc));
        end
        checkOutput({tag, ".count"},  bus.fetch_count,     eFc);
        checkOutput({tag, ".halted"}, 16'(bus.halted),     16'(eHalt));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".addr"},   16'(bus.leEndereco), 16'h0000);
        checkOutput({tag, ".valid"},  16'(bus.inst_valid), 16'h0000);
        checkOutput({tag, ".out"},    16'(bus.inst_out),   16'h0000);
        checkOutput({tag, ".pc"},     16'(bus.inst_pc),    16'h0000);
        checkOutput({tag, ".count"},  bus.fetch_count,     16'h0000);
        checkOutput({tag, ".halted"}, 16'(bus.halted),     16'h0000);
    endtask

    initial begin
        for (int a = 0; a < 256; a++)
            mem[a] = (a < 16) ? 8'(a + 16) : (8'(a) ^ 8'h80);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00);
        nextCycle();
        nextCycle();
        checkReset("reset0");
        reset = 1'b1;

        // Streaming from reset
        nextCycle(); checkState("s1", 8'h01, 1'b0, 8'h00, 8'h00, 16'd0, 1'b0);
        nextCycle(); checkState("s2", 8'h02, 1'b1, 8'h10, 8'h00, 16'd0, 1'b0);
        nextCycle(); checkState("s3", 8'h03, 1'b1, 8'h11, 8'h01, 16'd1, 1'b0);
        nextCycle(); checkState("s4", 8'h04, 1'b1, 8'h12, 8'h02, 16'd2, 1'b0);
        nextCycle(); checkState("s5", 8'h05, 1'b1, 8'h13, 8'h03, 16'd3, 1'b0);

        // Four stalled cycles with pc 3 at the head
        applyStimulus(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            nextCycle(); checkState("stall", 8'h05, 1'b1, 8'h13, 8'h03, 16'd3, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 8'h00);
        nextCycle(); checkState("r10", 8'h06, 1'b1, 8'h14, 8'h04, 16'd4, 1'b0);
        nextCycle(); checkState("r11", 8'h07, 1'b1, 8'h15, 8'h05, 16'd5, 1'b0);
        nextCycle(); checkState("r12", 8'h08, 1'b1, 8'h16, 8'h06, 16'd6, 1'b0);

        // Redirect to 0x20 drops pcs 6 and 7
        applyStimulus(1'b1, 1'b1, 8'h20);
        nextCycle(); checkState("d13", 8'h20, 1'b0, 8'h00, 8'h00, 16'd6, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        nextCycle(); checkState("d14", 8'h21, 1'b0, 8'h00, 8'h00, 16'd6, 1'b0);
        nextCycle(); checkState("d15", 8'h22, 1'b1, 8'hA0, 8'h20, 16'd6, 1'b0);
        nextCycle(); checkState("d16", 8'h23, 1'b1, 8'hA1, 8'h21, 16'd7, 1'b0);

        // Halt word at address 4
        mem[4] = 8'h30;
        applyStimulus(1'b1, 1'b1, 8'h00);
        nextCycle(); checkState("h17", 8'h00, 1'b0, 8'h00, 8'h00, 16'd7, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        nextCycle(); checkState("h18", 8'h01, 1'b0, 8'h00, 8'h00, 16'd7, 1'b0);
        nextCycle(); checkState("h19", 8'h02, 1'b1, 8'h10, 8'h00, 16'd7, 1'b0);
        nextCycle(); checkState("h20", 8'h03, 1'b1, 8'h11, 8'h01, 16'd8, 1'b0);
        nextCycle(); checkState("h21", 8'h04, 1'b1, 8'h12, 8'h02, 16'd9, 1'b0);
        nextCycle(); checkState("h22", 8'h05, 1'b1, 8'h13, 8'h03, 16'd10, 1'b0);
        nextCycle(); checkState("h23", 8'h05, 1'b1, 8'h30, 8'h04, 16'd11, 1'b0);
        nextCycle(); checkState("h24", 8'h05, 1'b0, 8'h00, 8'h00, 16'd12, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h50);
        nextCycle(); checkState("h25", 8'h05, 1'b0, 8'h00, 8'h00, 16'd12, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        nextCycle(); checkState("h26", 8'h05, 1'b0, 8'h00, 8'h00, 16'd12, 1'b1);

        // Asynchronous reset out of the halted state
        #2 reset = 1'b0;
        #1 checkReset("reset1");
        nextCycle();
        reset = 1'b1;
        nextCycle(); checkState("c28", 8'h01, 1'b0, 8'h00, 8'h00, 16'd0, 1'b0);
        nextCycle(); checkState("c29", 8'h02, 1'b1, 8'h10, 8'h00, 16'd0, 1'b0);
        nextCycle(); checkState("c30", 8'h03, 1'b1, 8'h11, 8'h01, 16'd1, 1'b0);
        nextCycle(); checkState("c31", 8'h04, 1'b1, 8'h12, 8'h02, 16'd2, 1'b0);
        nextCycle(); checkState("c32", 8'h05, 1'b1, 8'h13, 8'h03, 16'd3, 1'b0);

        // Redirect in the same cycle the halt word is captured
        applyStimulus(1'b1, 1'b1, 8'h40);
        nextCycle(); checkState("c33", 8'h40, 1'b0, 8'h00, 8'h00, 16'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        nextCycle(); checkState("c34", 8'h41, 1'b0, 8'h00, 8'h00, 16'd3, 1'b0);
        nextCycle(); checkState("c35", 8'h42, 1'b1, 8'hC0, 8'h40, 16'd3, 1'b0);
        nextCycle(); checkState("c36", 8'h43, 1'b1, 8'hC1, 8'h41, 16'd4, 1'b0);

        // PC wrap from 0xFF to 0x00
        applyStimulus(1'b1, 1'b1, 8'hFE);
        nextCycle(); checkState("w37", 8'hFE, 1'b0, 8'h00, 8'h00, 16'd4, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        nextCycle(); checkState("w38", 8'hFF, 1'b0, 8'h00, 8'h00, 16'd4, 1'b0);
        nextCycle(); checkState("w39", 8'h00, 1'b1, 8'h7E, 8'hFE, 16'd4, 1'b0);
        nextCycle(); checkState("w40", 8'h01, 1'b1, 8'h7F, 8'hFF, 16'd5, 1'b0);
        nextCycle(); checkState("w41", 8'h02, 1'b1, 8'h10, 8'h00, 16'd6, 1'b0);
        nextCycle(); checkState("w42", 8'h03, 1'b1, 8'h11, 8'h01, 16'd7, 1'b0);

        // Reset mid-stream, then restart from 0
        #2 reset = 1'b0;
        #1 checkReset("reset2");
        mem[4] = 8'h14;
        nextCycle(); checkReset("reset3");
        reset = 1'b1;
        nextCycle(); checkState("x44", 8'h01, 1'b0, 8'h00, 8'h00, 16'd0, 1'b0);
        nextCycle(); checkState("x45", 8'h02, 1'b1, 8'h10, 8'h00, 16'd0, 1'b0);
        nextCycle(); checkState("x46", 8'h03, 1'b1, 8'h11, 8'h01, 16'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
